// File: rtl/assoc_cache.sv
// -----------------------------------------------------------------------------
// assoc_cache
//   Set-associative, write-through, no-write-allocate cache with per-set LRU
//   ages, block fill from a word-wide memory port, an invalidate-all walk and
//   saturating hit/miss statistics.
//
//   Ports
//     clk_i, rst_ni        : rising-edge clock, asynchronous active-low reset
//     req_valid_i/_ready_o : CPU request handshake (accepted when both high)
//     req_write_i          : 1 = store, 0 = load
//     req_addr_i           : byte address (bit 0 ignored)
//     req_wdata_i          : store data
//     resp_valid_o         : one-cycle completion pulse
//     resp_rdata_o         : load data (0 for stores), held until next response
//     inv_i                : invalidate-all request, only honoured in IDLE
//     mem_req_o/mem_ack_i  : memory word transfer, request held until ack
//     mem_we_o             : 1 = memory write
//     mem_addr_o           : word-aligned memory address
//     mem_wdata_o          : memory write data
//     mem_rdata_i          : memory read data, valid with mem_ack_i
//     hit_count_o          : saturating hit counter
//     miss_count_o         : saturating miss counter
// -----------------------------------------------------------------------------
module assoc_cache #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int WAYS   = 2,
  parameter int SETS   = 64,
  parameter int WORDS  = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_valid_i,
  input  logic              req_write_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [DATA_W-1:0] req_wdata_i,
  output logic              req_ready_o,
  output logic              resp_valid_o,
  output logic [DATA_W-1:0] resp_rdata_o,
  input  logic              inv_i,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic [CNT_W-1:0]  hit_count_o,
  output logic [CNT_W-1:0]  miss_count_o
);

  localparam int OFF_W = $clog2(WORDS);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = ADDR_W - 1 - OFF_W - IDX_W;
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_FILL,
    S_WMEM,
    S_RESP,
    S_INVAL
  } state_e;

  state_e state_q, state_d;

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              write_q, write_d;
  logic [OFF_W-1:0]  cnt_q, cnt_d;
  logic [WAY_W-1:0]  victim_q, victim_d;
  logic [IDX_W-1:0]  inv_set_q, inv_set_d;
  logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;
  logic [CNT_W-1:0]  hit_cnt_q, hit_cnt_d;
  logic [CNT_W-1:0]  miss_cnt_q, miss_cnt_d;

  // Address fields of the incoming request and of the registered request
  logic [IDX_W-1:0] req_idx;
  logic [OFF_W-1:0] req_off;
  logic [TAG_W-1:0] cur_tag;
  logic [IDX_W-1:0] cur_idx;
  logic [OFF_W-1:0] cur_off;

  assign req_idx = req_addr_i[OFF_W+1 +: IDX_W];
  assign req_off = req_addr_i[1 +: OFF_W];
  assign cur_tag = addr_q[ADDR_W-1 -: TAG_W];
  assign cur_idx = addr_q[OFF_W+1 +: IDX_W];
  assign cur_off = addr_q[1 +: OFF_W];

  // Byte-select bit of the request is carried but never used
  logic unused_addr_bit;
  assign unused_addr_bit = addr_q[0];

  logic accept;
  assign accept = (state_q == S_IDLE) && !inv_i && req_valid_i;

  // Storage control from the FSM
  logic [WAYS-1:0]             data_we;
  logic [IDX_W+OFF_W-1:0]      data_waddr;
  logic [DATA_W-1:0]           data_wdata;
  logic [WAYS-1:0]             tag_we;
  logic                        valid_set_en;
  logic                        inv_clr_en;
  logic                        lru_en;
  logic [WAY_W-1:0]            lru_way;

  logic [DATA_W-1:0]           data_rd [WAYS];
  logic [TAG_W-1:0]            tag_rd  [WAYS];
  logic [SETS-1:0]             valid_q [WAYS];
  logic [WAY_W-1:0]            lru_oldest;

  // ---------------------------------------------------------------------------
  // Per-way data and tag RAMs. The read for the addressed set/word is launched
  // on acceptance so the registered output is ready in LOOKUP; no write can
  // happen between acceptance and LOOKUP.
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < WAYS; gi++) begin : g_way
      logic [DATA_W-1:0] data_mem [SETS*WORDS];
      logic [TAG_W-1:0]  tag_mem  [SETS];
      logic [DATA_W-1:0] data_rd_q;
      logic [TAG_W-1:0]  tag_rd_q;

      always_ff @(posedge clk_i) begin
        if (data_we[gi]) begin
          data_mem[data_waddr] <= data_wdata;
        end
        if (accept) begin
          data_rd_q <= data_mem[{req_idx, req_off}];
        end
      end

      always_ff @(posedge clk_i) begin
        if (tag_we[gi]) begin
          tag_mem[cur_idx] <= cur_tag;
        end
        if (accept) begin
          tag_rd_q <= tag_mem[req_idx];
        end
      end

      assign data_rd[gi] = data_rd_q;
      assign tag_rd[gi]  = tag_rd_q;
    end
  endgenerate

  // Valid bits: cleared one set per cycle by the invalidate walk, set by a
  // completed fill.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int w = 0; w < WAYS; w++) begin
        valid_q[w] <= '0;
      end
    end else begin
      if (inv_clr_en) begin
        for (int w = 0; w < WAYS; w++) begin
          valid_q[w][inv_set_q] <= 1'b0;
        end
      end
      if (valid_set_en) begin
        valid_q[victim_q][cur_idx] <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // LRU ages: the accessed way becomes 0, every younger way ages by one, so
  // the ages in a set stay a permutation and age WAYS-1 is the LRU way.
  // ---------------------------------------------------------------------------
  generate
    if (WAYS > 1) begin : g_lru
      logic [WAY_W-1:0] age_q [WAYS][SETS];
      logic [WAY_W-1:0] oldest;

      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          for (int w = 0; w < WAYS; w++) begin
            for (int s = 0; s < SETS; s++) begin
              age_q[w][s] <= WAY_W'(w);
            end
          end
        end else if (lru_en) begin
          for (int w = 0; w < WAYS; w++) begin
            if (WAY_W'(w) == lru_way) begin
              age_q[w][cur_idx] <= '0;
            end else if (age_q[w][cur_idx] < age_q[lru_way][cur_idx]) begin
              age_q[w][cur_idx] <= age_q[w][cur_idx] + WAY_W'(1);
            end
          end
        end
      end

      always_comb begin
        oldest = '0;
        for (int w = 0; w < WAYS; w++) begin
          if (age_q[w][cur_idx] == WAY_W'(WAYS - 1)) begin
            oldest = WAY_W'(w);
          end
        end
      end

      assign lru_oldest = oldest;
    end else begin : g_no_lru
      assign lru_oldest = '0;
    end
  endgenerate

  // Hit detection and victim choice for the registered request
  logic             hit;
  logic [WAY_W-1:0] hit_way;
  logic             has_free;
  logic [WAY_W-1:0] free_way;
  logic [WAY_W-1:0] victim_sel;

  always_comb begin
    hit      = 1'b0;
    hit_way  = '0;
    has_free = 1'b0;
    free_way = '0;
    // Descending scan so the lowest matching / lowest free way wins
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid_q[w][cur_idx] && (tag_rd[w] == cur_tag)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (!valid_q[w][cur_idx]) begin
        has_free = 1'b1;
        free_way = WAY_W'(w);
      end
    end
    victim_sel = has_free ? free_way : lru_oldest;
  end

  // ---------------------------------------------------------------------------
  // FSM state register and datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      wdata_q      <= '0;
      write_q      <= 1'b0;
      cnt_q        <= '0;
      victim_q     <= '0;
      inv_set_q    <= '0;
      resp_rdata_q <= '0;
      hit_cnt_q    <= '0;
      miss_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      write_q      <= write_d;
      cnt_q        <= cnt_d;
      victim_q     <= victim_d;
      inv_set_q    <= inv_set_d;
      resp_rdata_q <= resp_rdata_d;
      hit_cnt_q    <= hit_cnt_d;
      miss_cnt_q   <= miss_cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    write_d      = write_q;
    cnt_d        = cnt_q;
    victim_d     = victim_q;
    inv_set_d    = inv_set_q;
    resp_rdata_d = resp_rdata_q;
    hit_cnt_d    = hit_cnt_q;
    miss_cnt_d   = miss_cnt_q;
    data_we      = '0;
    data_waddr   = {cur_idx, cur_off};
    data_wdata   = wdata_q;
    tag_we       = '0;
    valid_set_en = 1'b0;
    inv_clr_en   = 1'b0;
    lru_en       = 1'b0;
    lru_way      = hit_way;

    case (state_q)
      S_IDLE: begin
        if (inv_i) begin
          inv_set_d = '0;
          state_d   = S_INVAL;
        end else if (req_valid_i) begin
          addr_d  = req_addr_i;
          wdata_d = req_wdata_i;
          write_d = req_write_i;
          state_d = S_LOOKUP;
        end
      end

      S_LOOKUP: begin
        if (hit) begin
          hit_cnt_d = (hit_cnt_q == {CNT_W{1'b1}}) ? hit_cnt_q : hit_cnt_q + CNT_W'(1);
        end else begin
          miss_cnt_d = (miss_cnt_q == {CNT_W{1'b1}}) ? miss_cnt_q : miss_cnt_q + CNT_W'(1);
        end

        if (write_q) begin
          // Write-through: update the cached copy only on a hit, always
          // forward the store to memory.
          if (hit) begin
            data_we[hit_way] = 1'b1;
            lru_en           = 1'b1;
          end
          state_d = S_WMEM;
        end else if (hit) begin
          resp_rdata_d = data_rd[hit_way];
          lru_en       = 1'b1;
          state_d      = S_RESP;
        end else begin
          victim_d = victim_sel;
          cnt_d    = '0;
          state_d  = S_FILL;
        end
      end

      S_FILL: begin
        data_waddr = {cur_idx, cnt_q};
        data_wdata = mem_rdata_i;
        if (mem_ack_i) begin
          data_we[victim_q] = 1'b1;
          if (cnt_q == cur_off) begin
            resp_rdata_d = mem_rdata_i;
          end
          cnt_d = cnt_q + OFF_W'(1);
          if (cnt_q == {OFF_W{1'b1}}) begin
            tag_we[victim_q] = 1'b1;
            valid_set_en     = 1'b1;
            lru_en           = 1'b1;
            lru_way          = victim_q;
            state_d          = S_RESP;
          end
        end
      end

      S_WMEM: begin
        if (mem_ack_i) begin
          resp_rdata_d = '0;
          state_d      = S_RESP;
        end
      end

      S_RESP: begin
        state_d = S_IDLE;
      end

      S_INVAL: begin
        inv_clr_en = 1'b1;
        inv_set_d  = inv_set_q + IDX_W'(1);
        if (inv_set_q == {IDX_W{1'b1}}) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs. Memory outputs are decoded from state so they drop to zero the
  // moment reset forces IDLE and stay stable while a word is outstanding.
  // ---------------------------------------------------------------------------
  assign req_ready_o  = (state_q == S_IDLE) && !inv_i;
  assign resp_valid_o = (state_q == S_RESP);
  assign resp_rdata_o = resp_rdata_q;
  assign mem_req_o    = (state_q == S_FILL) || (state_q == S_WMEM);
  assign mem_we_o     = (state_q == S_WMEM);
  assign mem_wdata_o  = (state_q == S_WMEM) ? wdata_q : '0;
  assign hit_count_o  = hit_cnt_q;
  assign miss_count_o = miss_cnt_q;

  always_comb begin
    mem_addr_o = '0;
    if (state_q == S_FILL) begin
      mem_addr_o = {addr_q[ADDR_W-1:OFF_W+1], cnt_q, 1'b0};
    end else if (state_q == S_WMEM) begin
      mem_addr_o = {addr_q[ADDR_W-1:1], 1'b0};
    end
  end

endmodule

// File: tb/tb_assoc_cache.sv
module tb_assoc_cache;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid, req_write;
  logic [15:0]   req_addr, req_wdata;
  logic          req_ready, resp_valid;
  logic [15:0]   resp_rdata;
  logic          inv;
  logic          mem_req, mem_we;
  logic [15:0]   mem_addr, mem_wdata;
  logic          mem_ack;
  logic [15:0]   mem_rdata;
  logic [CW-1:0] hit_count, miss_count;

  always #5 clk = ~clk;

  assoc_cache #(.CNT_W(CW)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .req_valid_i  (req_valid),
    .req_write_i  (req_write),
    .req_addr_i   (req_addr),
    .req_wdata_i  (req_wdata),
    .req_ready_o  (req_ready),
    .resp_valid_o (resp_valid),
    .resp_rdata_o (resp_rdata),
    .inv_i        (inv),
    .mem_req_o    (mem_req),
    .mem_we_o     (mem_we),
    .mem_addr_o   (mem_addr),
    .mem_wdata_o  (mem_wdata),
    .mem_ack_i    (mem_ack),
    .mem_rdata_i  (mem_rdata),
    .hit_count_o  (hit_count),
    .miss_count_o (miss_count)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference memory (what memory should contain) and the memory the DUT
  // actually talks to.
  logic [15:0] ref_mem  [32768];
  logic [15:0] phys_mem [32768];

  // Reference cache: per-line presence plus last-use timestamp for LRU
  logic        ref_valid [64][2];
  logic [5:0]  ref_tag   [64][2];
  int unsigned last_use  [64][2];
  int unsigned use_clock = 0;
  int          ref_hits, ref_misses;

  function automatic int sat(input int v);
    return (v > 15) ? 15 : v;
  endfunction

  function automatic void model_reset();
    for (int s = 0; s < 64; s++) begin
      for (int w = 0; w < 2; w++) ref_valid[s][w] = 1'b0;
    end
    ref_hits   = 0;
    ref_misses = 0;
  endfunction

  task automatic model_access(input logic wr, input logic [15:0] a, input logic [15:0] wd,
                              output logic hit, output logic [15:0] data);
    int s   = int'(a[9:4]);
    int way = -1;
    int vic;
    for (int w = 1; w >= 0; w--) begin
      if (ref_valid[s][w] && ref_tag[s][w] == a[15:10]) way = w;
    end
    hit = (way >= 0);
    use_clock++;
    if (hit) ref_hits++; else ref_misses++;
    if (wr) begin
      ref_mem[a[15:1]] = wd;
      if (hit) last_use[s][way] = use_clock;
      data = 16'h0000;
    end else begin
      if (!hit) begin
        vic = -1;
        for (int w = 1; w >= 0; w--) if (!ref_valid[s][w]) vic = w;
        if (vic < 0) vic = (last_use[s][0] < last_use[s][1]) ? 0 : 1;
        ref_valid[s][vic] = 1'b1;
        ref_tag[s][vic]   = a[15:10];
        way = vic;
      end
      last_use[s][way] = use_clock;
      data = ref_mem[a[15:1]];
    end
  endtask

  // Memory responder
  int          ack_delay = 0;
  int          n_rd = 0, n_wr = 0;
  logic [15:0] last_wr_addr = 16'h0, last_wr_data = 16'h0;
  logic [15:0] rd_log [$];

  initial begin
    int          wait_cnt;
    logic        busy;
    logic [15:0] cap_addr;
    logic        cap_we;
    mem_ack   = 1'b0;
    mem_rdata = 16'h0;
    wait_cnt  = 0;
    busy      = 1'b0;
    cap_addr  = 16'h0;
    cap_we    = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1) begin
        mem_ack = 1'b0;
        busy    = 1'b0;
      end else if (mem_ack) begin
        mem_ack = 1'b0;
        busy    = 1'b0;
      end else begin
        if (busy) begin
          chk("mem_stable", {15'h0, mem_req, mem_we, mem_addr}, {15'h0, 1'b1, cap_we, cap_addr});
        end else if (mem_req) begin
          busy     = 1'b1;
          cap_addr = mem_addr;
          cap_we   = mem_we;
          wait_cnt = 0;
        end
        if (busy) begin
          if (wait_cnt >= ack_delay) begin
            mem_ack = 1'b1;
            if (cap_we) begin
              phys_mem[cap_addr[15:1]] = mem_wdata;
              last_wr_addr = cap_addr;
              last_wr_data = mem_wdata;
              n_wr++;
            end else begin
              mem_rdata = phys_mem[cap_addr[15:1]];
              rd_log.push_back(cap_addr);
              n_rd++;
            end
          end else begin
            wait_cnt++;
          end
        end
      end
    end
  end

  // One request/response exchange; entered and left at a falling edge
  task automatic xact(input logic wr, input logic [15:0] a, input logic [15:0] wd,
                      output logic [15:0] rd, output int lat);
    int guard = 0;
    while (req_ready !== 1'b1 && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    chk("ready_timeout", 32'(guard >= 300), 32'h0);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = a;
    req_wdata = wd;
    @(negedge clk);
    req_valid = 1'b0;
    req_write = 1'b0;
    lat = 1;
    while (resp_valid !== 1'b1 && lat < 400) begin
      @(negedge clk);
      lat++;
    end
    chk("resp_timeout", 32'(lat >= 400), 32'h0);
    rd = resp_rdata;
    @(negedge clk);
    chk("resp_one_cycle", {31'h0, resp_valid}, 32'h0);
  endtask

  task automatic access(input logic wr, input logic [15:0] a, input logic [15:0] wd,
                        output logic hit);
    int          rd0 = n_rd;
    int          wr0 = n_wr;
    int          lat;
    logic [15:0] rd, exp;
    logic        mhit;
    logic [15:0] base;
    model_access(wr, a, wd, mhit, exp);
    xact(wr, a, wd, rd, lat);
    hit = mhit;
    chk(wr ? "store_rdata" : "load_rdata", rd, exp);
    if (wr) begin
      chk("store_wr_cnt", n_wr - wr0, 1);
      chk("store_wr_addr", last_wr_addr, {a[15:1], 1'b0});
      chk("store_wr_data", last_wr_data, wd);
      chk("store_rd_cnt", n_rd - rd0, 0);
    end else begin
      chk("load_rd_cnt", n_rd - rd0, mhit ? 0 : 8);
      chk("load_wr_cnt", n_wr - wr0, 0);
      if (mhit) begin
        chk("hit_latency", lat, 2);
      end else if (n_rd - rd0 == 8) begin
        base = {a[15:4], 4'h0};
        for (int i = 0; i < 8; i++) chk("fill_addr", rd_log[rd0 + i], base + 16'(2 * i));
      end
    end
    chk("hit_count", hit_count, sat(ref_hits));
    chk("miss_count", miss_count, sat(ref_misses));
    $display("%0t %s addr=%04h wdata=%04h rdata=%04h exp=%04h hit=%0d hits=%0d misses=%0d",
             $time, wr ? "ST" : "LD", a, wd, rd, exp, mhit, hit_count, miss_count);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);
  endtask

  initial begin
    logic        h;
    int          n;
    int          g;
    logic        saw;
    logic [15:0] a;

    rst_n = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_addr = 16'h0; req_wdata = 16'h0; inv = 1'b0;
    for (int i = 0; i < 32768; i++) begin
      ref_mem[i]  = 16'(16'h1000 + i);
      phys_mem[i] = 16'(16'h1000 + i);
    end
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset state
    chk("rst_req_ready", req_ready, 1);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_rdata", resp_rdata, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_hit_count", hit_count, 0);
    chk("rst_miss_count", miss_count, 0);

    // Cold miss then hit in the same block
    access(1'b0, 16'h0000, 16'h0, h);
    chk("cold_is_miss", h, 0);
    chk("cold_rdata", resp_rdata, 16'h1000);
    chk("cold_miss_count", miss_count, 1);
    access(1'b0, 16'h0004, 16'h0, h);
    chk("warm_is_hit", h, 1);
    chk("warm_rdata", resp_rdata, 16'h1002);
    chk("warm_hit_count", hit_count, 1);

    // LRU replacement in set 0
    access(1'b0, 16'h0000, 16'h0, h);
    access(1'b0, 16'h0400, 16'h0, h);
    chk("lru_0400_miss", h, 0);
    access(1'b0, 16'h0000, 16'h0, h);
    access(1'b0, 16'h0800, 16'h0, h);
    chk("lru_0800_miss", h, 0);
    access(1'b0, 16'h0000, 16'h0, h);
    chk("lru_0000_hit", h, 1);
    access(1'b0, 16'h0400, 16'h0, h);
    chk("lru_0400_evicted", h, 0);

    // Write-through store hit and no-allocate store miss
    access(1'b1, 16'h0006, 16'hBEEF, h);
    chk("st_hit_rdata0", resp_rdata, 0);
    chk("st_hit_waddr", last_wr_addr, 16'h0006);
    chk("st_hit_wdata", last_wr_data, 16'hBEEF);
    access(1'b0, 16'h0006, 16'h0, h);
    chk("st_then_ld_hit", h, 1);
    chk("st_then_ld_data", resp_rdata, 16'hBEEF);
    access(1'b1, 16'h2000, 16'h1234, h);
    chk("st_miss", h, 0);
    access(1'b0, 16'h2000, 16'h0, h);
    chk("st_miss_no_alloc", h, 0);
    chk("st_miss_ld_data", resp_rdata, 16'h1234);

    // Invalidate wins over a simultaneous request
    inv = 1'b1; req_valid = 1'b1; req_write = 1'b0; req_addr = 16'h0000;
    #1;
    chk("inv_ready_low", req_ready, 0);
    @(negedge clk);
    inv = 1'b0; req_valid = 1'b0;
    n = 0;
    while (req_ready !== 1'b1 && n < 200) begin
      n++;
      @(negedge clk);
    end
    chk("inval_cycles", n, 64);
    for (int s = 0; s < 64; s++) begin
      for (int w = 0; w < 2; w++) ref_valid[s][w] = 1'b0;
    end
    access(1'b0, 16'h0000, 16'h0, h);
    chk("after_inv_miss", h, 0);

    // Slow memory, then reset in the middle of a fill
    do_reset();
    ack_delay = 5;
    access(1'b0, 16'h0040, 16'h0, h);
    chk("slow_fill_miss", h, 0);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 16'h0000;
    @(negedge clk);
    req_valid = 1'b0;
    g = 0;
    while (!(mem_req === 1'b1 && mem_addr === 16'h0004) && g < 200) begin
      @(negedge clk);
      g++;
    end
    chk("third_word_timeout", 32'(g >= 200), 32'h0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_mem_req", mem_req, 0);
    chk("abort_mem_addr", mem_addr, 0);
    chk("abort_resp_valid", resp_valid, 0);
    chk("abort_miss_count", miss_count, 0);
    chk("abort_resp_rdata", resp_rdata, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    saw = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (resp_valid === 1'b1) saw = 1'b1;
    end
    chk("abort_no_resp", saw, 0);
    access(1'b0, 16'h0000, 16'h0, h);
    chk("abort_reload_miss", h, 0);

    // Randomised traffic over a small conflict-prone footprint
    do_reset();
    for (int t = 0; t < 150; t++) begin
      ack_delay = $urandom_range(0, 3);
      a = 16'(($urandom_range(0, 3) << 10) | ($urandom_range(0, 3) << 4) | ($urandom_range(0, 7) << 1));
      access(($urandom_range(0, 9) < 3), a, 16'($urandom), h);
    end

    // Counter saturation
    do_reset();
    ack_delay = 0;
    for (int i = 0; i < 20; i++) begin
      access(1'b0, 16'(i << 10), 16'h0, h);
    end
    chk("sat_miss_count", miss_count, 4'hF);
    chk("sat_hit_count", hit_count, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog
  initial begin
    #5000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/assoc_cache.md
ASSOC_CACHE -- requirements
Module: assoc_cache

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- ADDR_W, 16: byte address width.
- DATA_W, 16: word width.
- WAYS, 2: associativity; legal values 1, 2, 4.
- SETS, 64: sets; power of 2.
- WORDS, 8: words per block; power of 2.
- CNT_W, 16: statistics counter width.
- TAG_W = ADDR_W-1-log2(WORDS)-log2(SETS); the default is 6.
REQ-002 Ports (name, direction, width, meaning), one per line:
- clk, in, 1: single clock, rising edge.
- rst, in, 1: asynchronous, active-low reset.
- req_valid, in, 1: CPU request.
- req_write, in, 1: 1 = store, 0 = load.
- req_addr, in, ADDR_W: byte address; bit 0 ignored.
- req_wdata, in, DATA_W: store data.
- req_ready, out, 1: request accepted on req_valid & req_ready.
- resp_valid, out, 1: one-cycle completion pulse.
- resp_rdata, out, DATA_W: load data; 0 for stores.
- inv, in, 1: invalidate-all request.
- mem_req, out, 1: memory request, held until mem_ack.
- mem_we, out, 1: memory write.
- mem_addr, out, ADDR_W: word-aligned memory address.
- mem_wdata, out, DATA_W: memory write data.
- mem_ack, in, 1: memory completes one word.
- mem_rdata, in, DATA_W: read word, valid with mem_ack.
- hit_count, out, CNT_W: saturating hit counter.
- miss_count, out, CNT_W: saturating miss counter.

Function
REQ-003 Address split: tag = addr[ADDR_W-1 -: TAG_W], then index, then word offset, then bit 0.
REQ-004 States: IDLE, LOOKUP, FILL, WMEM, RESP, INVAL.
REQ-005 req_ready SHALL be 1 only in IDLE with inv=0. On acceptance, addr, wdata and write SHALL be registered and the FSM SHALL go to LOOKUP.
REQ-006 inv=1 in IDLE SHALL win over req_valid and enter INVAL. INVAL clears the valid bits of one set per cycle, sets 0..SETS-1, then returns to IDLE. inv outside IDLE is ignored.
REQ-007 LOOKUP: hit = any way with valid=1 and a matching tag. Hits and misses each increment their counter by 1, saturating at all-ones.
REQ-008 Load hit: the word is registered into resp_rdata, LRU is updated, and the FSM goes to RESP. resp_valid is therefore high exactly 2 cycles after acceptance.
REQ-009 Load miss: the victim is the lowest-index invalid way; otherwise the way with age WAYS-1. The FSM enters FILL with word counter = 0.
REQ-010 FILL: mem_req=1, mem_we=0, mem_addr = {tag, index, cnt, 1'b0}. mem_addr SHALL stay stable until mem_ack.
- Each mem_ack writes mem_rdata into the victim word cnt and increments cnt.
- When cnt equals the requested offset, mem_rdata is captured into resp_rdata.
- After the ack for word WORDS-1: the tag is written, valid=1, LRU is updated, and the FSM goes to RESP.
REQ-011 Store (write-through, no write-allocate), all from LOOKUP:
- On a hit, the word in the hit way is written and LRU is updated in LOOKUP.
- Hit or miss, the FSM then enters WMEM: mem_req=1, mem_we=1, mem_addr = request address with bit 0 = 0, mem_wdata = wdata, held until mem_ack.
- After mem_ack the FSM goes to RESP with resp_rdata=0.
REQ-012 RESP: resp_valid=1 for exactly one cycle, then IDLE. resp_rdata holds its value until the next response.
REQ-013 LRU: each set holds one log2(WAYS)-bit age per way. On access to way w, age[w]=0 and every way with age < old age[w] increments. Ages in a set SHALL remain a permutation of 0..WAYS-1. For WAYS=1 there is no LRU state.
REQ-014 mem_ack in IDLE, LOOKUP, RESP or INVAL SHALL be ignored. mem_req SHALL be 0 outside FILL and WMEM.

Reset
REQ-015 rst=0 SHALL immediately set:
- FSM = IDLE.
- All valid bits = 0; all ages = way index.
- Counters, resp_valid, resp_rdata, mem_req, mem_we, mem_addr, mem_wdata = 0.
- req_ready = 1 after release.
Data and tag storage is not reset.
REQ-016 Reset mid-FILL or mid-WMEM SHALL abandon the transaction. No resp_valid is produced for it.

Verification
REQ-017 After reset, load 0x0000 with mem_rdata = 0x1000+cnt:
- 8 reads at 0x0000..0x000E, resp_rdata = 0x1000, miss_count = 1.
- Then load 0x0004: resp_rdata = 0x1002 two cycles after acceptance, no mem_req, hit_count = 1.
REQ-018 Load 0x0000, 0x0400, 0x0000, then 0x0800:
- The 0x0800 fill evicts the way holding 0x0400.
- Next, load 0x0000 hits and load 0x0400 misses.
REQ-019 Store 0xBEEF to cached 0x0006:
- mem write addr 0x0006, data 0xBEEF; a later load 0x0006 hits with 0xBEEF.
- A store miss to 0x2000 writes memory only; a following load 0x2000 misses.
REQ-020 mem_ack delayed 5 cycles per word:
- mem_addr and mem_req stay stable while waiting.
- rst=0 during the 3rd fill word: outputs reset immediately, no resp_valid, and reloading 0x0000 misses.
REQ-021 inv=1 together with req_valid in IDLE:
- req_ready=0, then 64 INVAL cycles before req_ready=1.
- A previously cached 0x0000 then misses.
REQ-022 With CNT_W=4, 20 load misses SHALL leave miss_count=0xF.
